load_store_unit: RTL
====================

# load_store_unit

Load/store sequencer between the MEM-stage request and the byte-addressed 64-bit data memory. It accepts one RV64 load or store at a time. It performs read-modify-write for sub-doubleword stores, since the memory always writes 8 bytes. Loads are sign- or zero-extended, and misaligned, out-of-range and illegal requests are faulted without touching memory. Results return on a valid/ready response channel, and the pipeline stalls while `req_ready` is low.

## Interface
- `MEM_BYTES`, 512: data memory size in bytes; used for range fault.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV64 size/sign code.
- `req_address` input 64: byte address.
- `req_wdata` input 64: store data, LSB-aligned.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts response.
- `resp_rdata` output 64: extended load data; 0 for stores and faults.
- `resp_fault` output 1: request rejected, no memory access made.
- `mem_read` output 1: to memory.
- `mem_write` output 1: to memory; memory writes on rising edge.
- `mem_address` output 64: to memory.
- `mem_write_data` output 64: to memory.
- `mem_read_data` input 64: from memory, combinational read of bytes addr..addr+7, little-endian.

## Operation
- `funct3` codes:
  - 000 b, 001 h, 010 w, 011 d: signed loads, and the only legal stores.
  - 100 bu, 101 hu, 110 wu: unsigned loads.
  - 111: illegal.
- Size in bytes: 1, 2, 4 or 8.
- Request is accepted on an edge where `req_valid && req_ready`. Request fields are latched on that edge.
- Fault check runs at acceptance. A request faults on any of:
  - illegal `funct3`, or store with `funct3[2]` set;
  - address not a multiple of size;
  - address > MEM_BYTES − size. Compare this way so the check cannot overflow.
- FSM states: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - fault → RESP;
  - sd → WR;
  - any other request → RD.
- RD: `mem_read`=1 and `mem_address`=latched address. At the edge, `mem_read_data` is captured. Loads go to RESP; stores go to WR.
- WR: `mem_write`=1. `mem_write_data` = captured doubleword with its low size bytes replaced by `req_wdata`'s low bytes; sd uses `req_wdata` whole. Next state is RESP.
  - The RMW write-back covers 8 bytes. Bytes beyond MEM_BYTES are dropped by the memory.
- RESP: `resp_valid`=1, with `resp_rdata` and `resp_fault` held stable. On `resp_ready` the FSM returns to IDLE. There is no same-cycle re-accept.
- Load extraction: low size bytes of the captured data, sign-extended (b/h/w) or zero-extended (bu/hu/wu).
- `mem_read`, `mem_write` and `mem_write_data` are 0 outside RD/WR. `mem_address` holds the latched address at all times.

## Timing
- Reset (async assert): state IDLE. `req_ready`=1; all other outputs 0, and every internal register is cleared.
- Reset during WR forces IDLE immediately and drops `mem_write` before the edge, so no write occurs.
- Latency from accept edge to first `resp_valid` cycle:
  - load: 2 cycles;
  - sub-doubleword store: 3 cycles;
  - sd: 2 cycles;
  - fault: 1 cycle.
- Minimum issue interval is latency + 1 cycle, including the return to IDLE.
- `resp_valid` stays high, with data stable, for any number of cycles while `resp_ready`=0.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `lsu_pkg`:
  - `funct3` localparams (LSU_B … LSU_WU);
  - 2-bit FSM state encoding;
  - size-from-funct3 function.
- Sub-module `lsu_align`: purely combinational. It does store byte merge (old, wdata, funct3 → merged) and load extract/extend (raw, funct3 → rdata). It is reused by both the RD capture path and the WR data path.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all outputs 0 immediately. After release, `req_ready`=1.
- sd 0x1122334455667788 at 0x10 → `mem_read` never asserted and `mem_write` high for exactly 1 cycle. Then ld 0x10 → `resp_rdata`=0x1122334455667788, `resp_fault`=0, `resp_valid` 2 cycles after accept.
- sb 0xAB at 0x12 (RD then WR) → ld 0x10 returns 0x1122334455AB7788.
- Load extension checks after the previous step:

  | Load | `resp_rdata` |
  |---|---|
  | lb 0x12 | 0xFFFFFFFFFFFFFFAB |
  | lbu 0x12 | 0xAB |
  | lh 0x10 | 0x7788 |
  | lw 0x14 | 0x11223344 |
  | lwu 0x10 | 0x55AB7788 |

- Faults → `resp_fault`=1, `resp_rdata`=0, no `mem_read`/`mem_write` pulses, `resp_valid` 1 cycle after accept. Cases:
  - lw at 0x11;
  - `funct3`=111;
  - sb with `funct3`=100;
  - ld at 0x1FC with MEM_BYTES=512;
  - ld at 0xFFFFFFFFFFFFFFF8.
- Backpressure and reset abort:
  - hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata` and `req_ready`=0 stable throughout;
  - assert reset during the WR cycle of sw 0xDEADBEEF at 0x20 → a later ld 0x20 returns the prior contents unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding
// and the access-size decode.
package lsu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [2:0] LSU_B   = 3'b000;
    localparam logic [2:0] LSU_H   = 3'b001;
    localparam logic [2:0] LSU_W   = 3'b010;
    localparam logic [2:0] LSU_D   = 3'b011;
    localparam logic [2:0] LSU_BU  = 3'b100;
    localparam logic [2:0] LSU_HU  = 3'b101;
    localparam logic [2:0] LSU_WU  = 3'b110;
    localparam logic [2:0] LSU_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
    function automatic logic [3:0] lsu_size(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: store byte merge into an old doubleword and
// load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_data,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] raw_data,
    output logic [XLEN-1:0] merged_c,
    output logic [XLEN-1:0] rdata_c
);

    logic [3:0] size;
    logic       sign;

    always_comb begin
        size = lsu_size(funct3);
        case (funct3[1:0])
            2'b00:   sign = raw_data[7];
            2'b01:   sign = raw_data[15];
            2'b10:   sign = raw_data[31];
            default: sign = 1'b0;
        endcase
        if (funct3[2]) begin
            sign = 1'b0;
        end
        merged_c = old_data;
        rdata_c  = '0;
        // Low size bytes come from the new data; the rest keep old / get extension.
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < size) begin
                merged_c[i*8 +: 8] = wdata[i*8 +: 8];
                rdata_c[i*8 +: 8]  = raw_data[i*8 +: 8];
            end else begin
                rdata_c[i*8 +: 8]  = {8{sign}};
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV64 load/store sequencer with read-modify-write for
// sub-doubleword stores and fault screening before any memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_address,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    lsu_state_e      state_q, state_n;
    logic [XLEN-1:0] addr_q, addr_n;
    logic [XLEN-1:0] wdata_q, wdata_n;
    logic [2:0]      funct3_q, funct3_n;
    logic            write_q, write_n;
    logic [XLEN-1:0] rdata_n;
    logic            fault_n;
    logic [XLEN-1:0] mem_wdata_n;

    logic [3:0]      req_size;
    logic            req_fault;
    logic [2:0]      al_funct3;
    logic [XLEN-1:0] al_old, al_wdata, al_merged, al_rdata;

    // Fault screen on the incoming request; range compare written to avoid overflow.
    always_comb begin
        req_size  = lsu_size(req_funct3);
        req_fault = (req_funct3 == LSU_ILL) || (req_write && req_funct3[2])
                 || ((req_address & (XLEN'(req_size) - XLEN'(1))) != '0)
                 || (req_address > (XLEN'(MEM_BYTES) - XLEN'(req_size)));
    end

    // In IDLE the aligner sees the live request (sd path); otherwise latched fields.
    assign al_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
    assign al_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
    assign al_old    = (state_q == ST_RD)   ? mem_read_data : '0;

    lsu_align u_align (
        .funct3   (al_funct3),
        .old_data (al_old),
        .wdata    (al_wdata),
        .raw_data (mem_read_data),
        .merged_c (al_merged),
        .rdata_c  (al_rdata)
    );

    always_comb begin
        state_n  = state_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        funct3_n = funct3_q;
        write_n  = write_q;
        rdata_n  = resp_rdata;
        fault_n  = resp_fault;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_n   = req_address;
                    wdata_n  = req_wdata;
                    funct3_n = req_funct3;
                    write_n  = req_write;
                    rdata_n  = '0;
                    fault_n  = req_fault;
                    if (req_fault) begin
                        state_n = ST_RESP;
                    end else if (req_write && (req_funct3 == LSU_D)) begin
                        state_n = ST_WR;
                    end else begin
                        state_n = ST_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_n = write_q ? '0 : al_rdata;
                state_n = write_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rdata_n = '0;
                    fault_n = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        mem_wdata_n = (state_n == ST_WR) ? al_merged : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            funct3_q       <= '0;
            write_q        <= 1'b0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_fault     <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_write_data <= '0;
        end else begin
            state_q        <= state_n;
            addr_q         <= addr_n;
            wdata_q        <= wdata_n;
            funct3_q       <= funct3_n;
            write_q        <= write_n;
            req_ready      <= (state_n == ST_IDLE);
            resp_valid     <= (state_n == ST_RESP);
            resp_rdata     <= rdata_n;
            resp_fault     <= fault_n;
            mem_read       <= (state_n == ST_RD);
            mem_write      <= (state_n == ST_WR);
            mem_write_data <= mem_wdata_n;
        end
    end

    assign mem_address = addr_q;

endmodule
